perf_counter_bank: RTL and testbench

//   Parametrised bank of event counters for the pipelined core: cycles, instructions, stalls, loads, stores, ALU/control ops.

---
 rtl/perf_counter_bank.sv | 132 +++++++++++++
 tb/tb_perf_counter_bank.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/perf_counter_bank.sv
// Bank of event counters with wrap/saturate, sticky overflow, freeze and an
// atomic snapshot into a shadow bank read through a registered port.

module perf_counter_lane #(
    parameter int CNT_W    = 16,
    parameter int INC_W    = 2,
    parameter int SAT_MODE = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inc_en,
    input  logic [INC_W-1:0] inc_val,
    input  logic             freeze,
    input  logic             clr,
    input  logic             snap,
    output logic [CNT_W-1:0] cnt,
    output logic             ovf,
    output logic [CNT_W-1:0] shadow,
    output logic             sovf
);

    logic [CNT_W:0] sum;
    logic           bump;

    assign sum  = {1'b0, cnt} + {{(CNT_W + 1 - INC_W){1'b0}}, inc_val};
    assign bump = inc_en && !freeze && (inc_val != '0);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt <= '0;
            ovf <= 1'b0;
        end else if (clr) begin
            cnt <= '0;
            ovf <= 1'b0;
        end else if (bump) begin
            if (sum[CNT_W]) begin
                ovf <= 1'b1;
                cnt <= (SAT_MODE != 0) ? {CNT_W{1'b1}} : sum[CNT_W-1:0];
            end else begin
                cnt <= sum[CNT_W-1:0];
            end
        end
    end

    // Shadow takes the pre-edge live value, so a snap+clr is a lossless read-and-clear.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            shadow <= '0;
            sovf   <= 1'b0;
        end else if (snap) begin
            shadow <= cnt;
            sovf   <= ovf;
        end
    end

endmodule

module perf_counter_bank #(
    parameter int NUM_CNT  = 7,
    parameter int CNT_W    = 16,
    parameter int INC_W    = 2,
    parameter int SAT_MODE = 0,
    parameter int IDX_W    = 3
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NUM_CNT-1:0]       inc_en,
    input  logic [NUM_CNT*INC_W-1:0] inc_val,
    input  logic                     freeze,
    input  logic                     clr,
    input  logic                     snap,
    input  logic [IDX_W-1:0]         rd_idx,
    output logic [CNT_W-1:0]         rd_data,
    output logic                     rd_ovf,
    output logic [NUM_CNT-1:0]       ovf,
    output logic                     snap_valid
);

    logic [NUM_CNT-1:0][CNT_W-1:0] cnt;
    logic [NUM_CNT-1:0][CNT_W-1:0] shadow;
    logic [NUM_CNT-1:0]            sovf;
    logic [CNT_W-1:0]              rd_sel;
    logic                          rd_sel_ovf;

    genvar g;
    generate
        for (g = 0; g < NUM_CNT; g++) begin : g_lane
            perf_counter_lane #(
                .CNT_W    (CNT_W),
                .INC_W    (INC_W),
                .SAT_MODE (SAT_MODE)
            ) u_lane (
                .clk     (clk),
                .reset   (reset),
                .inc_en  (inc_en[g]),
                .inc_val (inc_val[g*INC_W +: INC_W]),
                .freeze  (freeze),
                .clr     (clr),
                .snap    (snap),
                .cnt     (cnt[g]),
                .ovf     (ovf[g]),
                .shadow  (shadow[g]),
                .sovf    (sovf[g])
            );
        end
    endgenerate

    // Out-of-range indices match no channel and read back as zero.
    always_comb begin
        rd_sel     = '0;
        rd_sel_ovf = 1'b0;
        for (int i = 0; i < NUM_CNT; i++) begin
            if (rd_idx == IDX_W'(i)) begin
                rd_sel     = shadow[i];
                rd_sel_ovf = sovf[i];
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_data    <= '0;
            rd_ovf     <= 1'b0;
            snap_valid <= 1'b0;
        end else begin
            rd_data <= rd_sel;
            rd_ovf  <= rd_sel_ovf;
            if (snap) snap_valid <= 1'b1;
        end
    end

endmodule

// File: tb/tb_perf_counter_bank.sv
// Directed bench: a wrap-mode and a saturate-mode bank (CNT_W=4) share one
// stimulus stream; counter values are observed through snap + read port.

module tb_perf_counter_bank;

    localparam int NUM_CNT = 7;
    localparam int CNT_W   = 4;
    localparam int INC_W   = 2;
    localparam int IDX_W   = 3;

    logic                     clk;
    logic                     reset;
    logic [NUM_CNT-1:0]       inc_en;
    logic [NUM_CNT*INC_W-1:0] inc_val;
    logic                     freeze;
    logic                     clr;
    logic                     snap;
    logic [IDX_W-1:0]         rd_idx;

    logic [CNT_W-1:0]   w_rd_data, s_rd_data;
    logic               w_rd_ovf, s_rd_ovf;
    logic [NUM_CNT-1:0] w_ovf, s_ovf;
    logic               w_snap_valid, s_snap_valid;

    int vectors    = 0;
    int miscompares = 0;

    perf_counter_bank #(.NUM_CNT(NUM_CNT), .CNT_W(CNT_W), .INC_W(INC_W), .SAT_MODE(0), .IDX_W(IDX_W)) dut_w (
        .clk(clk), .reset(reset), .inc_en(inc_en), .inc_val(inc_val), .freeze(freeze),
        .clr(clr), .snap(snap), .rd_idx(rd_idx), .rd_data(w_rd_data), .rd_ovf(w_rd_ovf),
        .ovf(w_ovf), .snap_valid(w_snap_valid)
    );

    perf_counter_bank #(.NUM_CNT(NUM_CNT), .CNT_W(CNT_W), .INC_W(INC_W), .SAT_MODE(1), .IDX_W(IDX_W)) dut_s (
        .clk(clk), .reset(reset), .inc_en(inc_en), .inc_val(inc_val), .freeze(freeze),
        .clr(clr), .snap(snap), .rd_idx(rd_idx), .rd_data(s_rd_data), .rd_ovf(s_rd_ovf),
        .ovf(s_ovf), .snap_valid(s_snap_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Snapshot everything, then present channel idx on the read port.
    task automatic read_ch(input int idx);
        snap   = 1'b1;
        rd_idx = IDX_W'(idx);
        tick();
        snap = 1'b0;
        tick();
    endtask

    logic [NUM_CNT*INC_W-1:0] mixed;

    initial begin
        reset = 1'b0; inc_en = '0; inc_val = '0; freeze = 1'b0;
        clr = 1'b0; snap = 1'b0; rd_idx = '0;
        #3;
        chk("rst_w_rd_data", 32'(w_rd_data), 0);
        chk("rst_w_rd_ovf", 32'(w_rd_ovf), 0);
        chk("rst_w_ovf", 32'(w_ovf), 0);
        chk("rst_s_snap_valid", 32'(s_snap_valid), 0);
        tick(); tick();
        reset = 1'b1;

        // Count channel 0 to 5, then pull reset mid-cycle.
        inc_en = 7'b0000001; inc_val = 14'd1;
        repeat (5) tick();
        inc_en = '0;
        read_ch(0);
        chk("cnt5_w", 32'(w_rd_data), 5);
        chk("cnt5_s", 32'(s_rd_data), 5);
        chk("snap_valid_set", 32'(w_snap_valid), 1);
        reset = 1'b0;
        #1;
        chk("async_rst_rd_data", 32'(w_rd_data), 0);
        chk("async_rst_snap_valid", 32'(w_snap_valid), 0);
        chk("async_rst_s_rd_data", 32'(s_rd_data), 0);
        #2;
        reset = 1'b1;
        tick();
        chk("snap_valid_pre", 32'(w_snap_valid), 0);
        read_ch(0);
        chk("cnt_after_rst", 32'(w_rd_data), 0);

        // Overflow: 14 + 3 wraps to 1 or saturates at 15.
        inc_en = 7'b0000001; inc_val = 14'd3;
        repeat (4) tick();
        inc_val = 14'd2;
        tick();
        chk("pre_ovf_w", 32'(w_ovf), 0);
        chk("pre_ovf_s", 32'(s_ovf), 0);
        inc_val = 14'd3;
        tick();
        chk("ovf_w", 32'(w_ovf), 32'h01);
        chk("ovf_s", 32'(s_ovf), 32'h01);
        inc_val = 14'd1;
        tick();
        inc_en = '0;
        read_ch(0);
        chk("wrap_cnt", 32'(w_rd_data), 2);
        chk("wrap_rd_ovf", 32'(w_rd_ovf), 1);
        chk("sat_cnt", 32'(s_rd_data), 15);
        chk("sat_rd_ovf", 32'(s_rd_ovf), 1);
        chk("ovf_sticky_w", 32'(w_ovf), 32'h01);

        rd_idx = 3'd7;
        tick();
        chk("oob_rd_data", 32'(s_rd_data), 0);
        chk("oob_rd_ovf", 32'(s_rd_ovf), 0);

        // Read-and-clear on channel 2 at count 9.
        clr = 1'b1;
        tick();
        clr = 1'b0;
        chk("clr_ovf_w", 32'(w_ovf), 0);
        chk("clr_ovf_s", 32'(s_ovf), 0);
        inc_en = 7'b0000100; inc_val = 14'(3 << 4);
        repeat (3) tick();
        inc_val = 14'(1 << 4);
        snap = 1'b1; clr = 1'b1; rd_idx = 3'd2;
        tick();
        chk("rac_old_shadow", 32'(w_rd_data), 0);
        snap = 1'b0; clr = 1'b0; inc_en = '0;
        tick();
        chk("rac_shadow_w", 32'(w_rd_data), 9);
        chk("rac_shadow_s", 32'(s_rd_data), 9);
        chk("rac_rd_ovf", 32'(w_rd_ovf), 0);
        read_ch(2);
        chk("rac_live_cleared", 32'(w_rd_data), 0);

        // Freeze for 3 cycles, then two counting cycles with mixed increments.
        mixed = '0;
        for (int i = 0; i < NUM_CNT; i++) mixed[i*INC_W +: INC_W] = INC_W'((i % 3) + 1);
        inc_val = mixed; inc_en = '1; freeze = 1'b1;
        repeat (3) tick();
        read_ch(2);
        chk("frz_hold_ch2", 32'(w_rd_data), 0);
        chk("frz_ovf", 32'(w_ovf), 0);
        freeze = 1'b0;
        tick(); tick();
        inc_en = '0;
        read_ch(0); chk("run_ch0", 32'(w_rd_data), 2);
        read_ch(1); chk("run_ch1", 32'(w_rd_data), 4);
        read_ch(2); chk("run_ch2", 32'(s_rd_data), 6);
        read_ch(5); chk("run_ch5", 32'(w_rd_data), 6);
        read_ch(6); chk("run_ch6", 32'(s_rd_data), 2);
        chk("snap_valid_final", 32'(s_snap_valid), 1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
